// File: rtl/axi_burst_initiator.sv
// axi_burst_initiator
//   AXI4 master-side traffic initiator. Takes one command at a time (write or
//   read INCR burst, 1..16 beats). Write data is cmd_seed + beat index, and
//   read data is checked against the same pattern. Each command ends with one
//   completion on the rsp_* handshake.
//
// Ports
//   ACLK, ARESET          clock, asynchronous active-high reset
//   cmd_*                 command handshake and fields (write/addr/len/id/seed)
//   rsp_*                 completion handshake, worst response, read-data
//                         error count, protocol-error flag
//   M_AW*, M_W*, M_B*     AXI write address / data / response channels
//   M_AR*, M_R*           AXI read address / data channels
//   M_Ax{LOCK,CACHE,PROT,QOS,REGION,USER}   tied to zero
//
// state  | meaning
// IDLE   | waiting for a command (cmd_ready high)
// WR     | AW and W bursts in flight, independent handshakes
// WRESP  | waiting for the B response
// RADDR  | AR held until accepted
// RDATA  | accepting and checking R beats until RLAST
// RESP   | completion presented until rsp_ready
module axi_burst_initiator #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,
    input  logic [DATA_WIDTH-1:0]   cmd_seed,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_resp,
    output logic [4:0]              rsp_errs,
    output logic                    rsp_proto_err,

    output logic [ID_WIDTH-1:0]     M_AWID,
    output logic [ADDR_WIDTH-1:0]   M_AWADDR,
    output logic [7:0]              M_AWLEN,
    output logic [2:0]              M_AWSIZE,
    output logic [1:0]              M_AWBURST,
    output logic                    M_AWLOCK,
    output logic [3:0]              M_AWCACHE,
    output logic [2:0]              M_AWPROT,
    output logic [3:0]              M_AWQOS,
    output logic [3:0]              M_AWREGION,
    output logic                    M_AWUSER,
    output logic                    M_AWVALID,
    input  logic                    M_AWREADY,

    output logic [DATA_WIDTH-1:0]   M_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_WSTRB,
    output logic                    M_WLAST,
    output logic                    M_WVALID,
    input  logic                    M_WREADY,

    input  logic [ID_WIDTH-1:0]     M_BID,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_BVALID,
    output logic                    M_BREADY,

    output logic [ID_WIDTH-1:0]     M_ARID,
    output logic [ADDR_WIDTH-1:0]   M_ARADDR,
    output logic [7:0]              M_ARLEN,
    output logic [2:0]              M_ARSIZE,
    output logic [1:0]              M_ARBURST,
    output logic                    M_ARLOCK,
    output logic [3:0]              M_ARCACHE,
    output logic [2:0]              M_ARPROT,
    output logic [3:0]              M_ARQOS,
    output logic [3:0]              M_ARREGION,
    output logic                    M_ARUSER,
    output logic                    M_ARVALID,
    input  logic                    M_ARREADY,

    input  logic [ID_WIDTH-1:0]     M_RID,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP,
    input  logic                    M_RLAST,
    input  logic                    M_RVALID,
    output logic                    M_RREADY
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_RESP
    } state_t;

    state_t                 state;
    logic [ID_WIDTH-1:0]    cmd_id_q;
    logic [LEN_WIDTH-1:0]   cmd_len_q;
    logic [DATA_WIDTH-1:0]  cmd_seed_q;
    logic [7:0]             beat;
    logic                   aw_done;
    logic                   w_done;

    logic [ADDR_WIDTH-1:0]  addr_al;
    logic [31:0]            end_off;
    logic                   crosses_4k;
    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [DATA_WIDTH-1:0]  r_expect;

    assign M_AWSIZE   = 3'(SIZE);
    assign M_AWBURST  = 2'b01;
    assign M_AWLOCK   = 1'b0;
    assign M_AWCACHE  = 4'd0;
    assign M_AWPROT   = 3'd0;
    assign M_AWQOS    = 4'd0;
    assign M_AWREGION = 4'd0;
    assign M_AWUSER   = 1'b0;
    assign M_ARSIZE   = 3'(SIZE);
    assign M_ARBURST  = 2'b01;
    assign M_ARLOCK   = 1'b0;
    assign M_ARCACHE  = 4'd0;
    assign M_ARPROT   = 3'd0;
    assign M_ARQOS    = 4'd0;
    assign M_ARREGION = 4'd0;
    assign M_ARUSER   = 1'b0;

    assign cmd_ready = (state == S_IDLE) && !ARESET;

    // Start address is forced onto a beat boundary; the burst must end
    // at or before the next 4 KB page boundary.
    assign addr_al    = cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
    assign end_off    = 32'(addr_al[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE);
    assign crosses_4k = end_off > 32'd4096;

    assign aw_hs    = M_AWVALID && M_AWREADY;
    assign w_hs     = M_WVALID && M_WREADY;
    assign b_hs     = M_BVALID && M_BREADY;
    assign ar_hs    = M_ARVALID && M_ARREADY;
    assign r_hs     = M_RVALID && M_RREADY;
    assign r_expect = cmd_seed_q + DATA_WIDTH'(beat);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state         <= S_IDLE;
            cmd_id_q      <= '0;
            cmd_len_q     <= '0;
            cmd_seed_q    <= '0;
            beat          <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_resp      <= 2'b00;
            rsp_errs      <= 5'd0;
            rsp_proto_err <= 1'b0;
            M_AWID        <= '0;
            M_AWADDR      <= '0;
            M_AWLEN       <= 8'd0;
            M_AWVALID     <= 1'b0;
            M_WDATA       <= '0;
            M_WSTRB       <= '0;
            M_WLAST       <= 1'b0;
            M_WVALID      <= 1'b0;
            M_BREADY      <= 1'b0;
            M_ARID        <= '0;
            M_ARADDR      <= '0;
            M_ARLEN       <= 8'd0;
            M_ARVALID     <= 1'b0;
            M_RREADY      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_id_q      <= cmd_id;
                        cmd_len_q     <= cmd_len;
                        cmd_seed_q    <= cmd_seed;
                        beat          <= 8'd0;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        rsp_errs      <= 5'd0;
                        if (crosses_4k) begin
                            rsp_resp      <= 2'b10;
                            rsp_proto_err <= 1'b1;
                            rsp_valid     <= 1'b1;
                            state         <= S_RESP;
                        end else begin
                            rsp_resp      <= 2'b00;
                            rsp_proto_err <= 1'b0;
                            if (cmd_write) begin
                                M_AWID    <= cmd_id;
                                M_AWADDR  <= addr_al;
                                M_AWLEN   <= 8'(cmd_len);
                                M_AWVALID <= 1'b1;
                                M_WDATA   <= cmd_seed;
                                M_WSTRB   <= '1;
                                M_WLAST   <= (cmd_len == '0);
                                M_WVALID  <= 1'b1;
                                state     <= S_WR;
                            end else begin
                                M_ARID    <= cmd_id;
                                M_ARADDR  <= addr_al;
                                M_ARLEN   <= 8'(cmd_len);
                                M_ARVALID <= 1'b1;
                                state     <= S_RADDR;
                            end
                        end
                    end
                end

                S_WR: begin
                    if (aw_hs) begin
                        M_AWVALID <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        if (M_WLAST) begin
                            M_WVALID <= 1'b0;
                            w_done   <= 1'b1;
                        end else begin
                            M_WDATA <= M_WDATA + 1'b1;
                            beat    <= beat + 8'd1;
                            M_WLAST <= ((beat + 8'd1) == 8'(cmd_len_q));
                        end
                    end
                    // Either handshake may be the later one, or both may land together.
                    if ((aw_done || aw_hs) && (w_done || (w_hs && M_WLAST))) begin
                        M_BREADY <= 1'b1;
                        state    <= S_WRESP;
                    end
                end

                S_WRESP: begin
                    if (b_hs) begin
                        M_BREADY  <= 1'b0;
                        rsp_resp  <= M_BRESP;
                        if (M_BID != cmd_id_q)
                            rsp_proto_err <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end

                S_RADDR: begin
                    if (ar_hs) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= S_RDATA;
                    end
                end

                S_RDATA: begin
                    if (r_hs) begin
                        beat <= beat + 8'd1;
                        if ((M_RDATA != r_expect) && (rsp_errs != 5'd31))
                            rsp_errs <= rsp_errs + 5'd1;
                        if (M_RID != cmd_id_q)
                            rsp_proto_err <= 1'b1;
                        if (M_RRESP > rsp_resp)
                            rsp_resp <= M_RRESP;
                        if (M_RLAST) begin
                            if (beat != 8'(cmd_len_q))
                                rsp_proto_err <= 1'b1;
                            M_RREADY  <= 1'b0;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_initiator.sv
// Directed bench for axi_burst_initiator. Inputs are driven and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_axi_burst_initiator;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic [31:0] cmd_seed;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_resp;
    logic [4:0]  rsp_errs;
    logic        rsp_proto_err;

    logic [3:0]  M_AWID;
    logic [31:0] M_AWADDR;
    logic [7:0]  M_AWLEN;
    logic [2:0]  M_AWSIZE;
    logic [1:0]  M_AWBURST;
    logic        M_AWLOCK;
    logic [3:0]  M_AWCACHE;
    logic [2:0]  M_AWPROT;
    logic [3:0]  M_AWQOS;
    logic [3:0]  M_AWREGION;
    logic        M_AWUSER;
    logic        M_AWVALID, M_AWREADY;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WLAST, M_WVALID, M_WREADY;
    logic [3:0]  M_BID;
    logic [1:0]  M_BRESP;
    logic        M_BVALID, M_BREADY;
    logic [3:0]  M_ARID;
    logic [31:0] M_ARADDR;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic        M_ARLOCK;
    logic [3:0]  M_ARCACHE;
    logic [2:0]  M_ARPROT;
    logic [3:0]  M_ARQOS;
    logic [3:0]  M_ARREGION;
    logic        M_ARUSER;
    logic        M_ARVALID, M_ARREADY;
    logic [3:0]  M_RID;
    logic [31:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST, M_RVALID, M_RREADY;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 ACLK = ~ACLK;

    axi_burst_initiator dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id), .cmd_seed(cmd_seed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
        .rsp_errs(rsp_errs), .rsp_proto_err(rsp_proto_err),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
        .M_AWBURST(M_AWBURST), .M_AWLOCK(M_AWLOCK), .M_AWCACHE(M_AWCACHE),
        .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS), .M_AWREGION(M_AWREGION),
        .M_AWUSER(M_AWUSER), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARLOCK(M_ARLOCK), .M_ARCACHE(M_ARCACHE),
        .M_ARPROT(M_ARPROT), .M_ARQOS(M_ARQOS), .M_ARREGION(M_ARREGION),
        .M_ARUSER(M_ARUSER), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    // Presents one command for a single cycle; returns on the falling edge
    // after the capturing rising edge.
    task automatic issue_cmd(input logic wr, input logic [31:0] addr,
                             input logic [3:0] len, input logic [3:0] id,
                             input logic [31:0] seed);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_id    = id;
        cmd_seed  = seed;
        cmd_valid = 1'b1;
        @(negedge ACLK);
        cmd_valid = 1'b0;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge ACLK);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %0b want 0", cmd_ready); else n_pass++;
        n_checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid} !== 6'b0)
            $display("FAIL rst_valids got %b want 000000",
                     {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid});
        else n_pass++;
        n_checks++;
        if ({M_AWADDR, M_WDATA, M_ARADDR} !== 96'b0) $display("FAIL rst_addr_data not zero"); else n_pass++;
        n_checks++;
        if ({rsp_resp, rsp_errs, rsp_proto_err} !== 8'b0)
            $display("FAIL rst_rsp_fields got %b want 0", {rsp_resp, rsp_errs, rsp_proto_err});
        else n_pass++;
        ARESET = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready got %0b want 1", cmd_ready); else n_pass++;
        @(negedge ACLK);
    endtask

    task automatic test_write();
        M_AWREADY = 1'b1;
        M_WREADY  = 1'b1;
        issue_cmd(1'b1, 32'h100, 4'd3, 4'd6, 32'hA0);
        n_checks++;
        if ({M_AWVALID, M_WVALID} !== 2'b11) $display("FAIL wr_valids got %b want 11", {M_AWVALID, M_WVALID}); else n_pass++;
        n_checks++;
        if ({M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID} !== {32'h100, 8'd3, 3'd2, 2'b01, 4'd6})
            $display("FAIL wr_aw_fields got addr %0h len %0d size %0d burst %0d id %0d",
                     M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID);
        else n_pass++;
        n_checks++;
        if (M_WSTRB !== 4'hF) $display("FAIL wr_wstrb got %0h want f", M_WSTRB); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (M_WDATA !== 32'hA0 + 32'(k)) $display("FAIL wr_wdata beat %0d got %0h want %0h", k, M_WDATA, 32'hA0 + 32'(k)); else n_pass++;
            n_checks++;
            if (M_WLAST !== (k == 3)) $display("FAIL wr_wlast beat %0d got %0b want %0b", k, M_WLAST, (k == 3)); else n_pass++;
            n_checks++;
            if (M_BREADY !== 1'b0) $display("FAIL wr_bready_early beat %0d got 1 want 0", k); else n_pass++;
            if (k == 1) begin
                n_checks++;
                if (M_AWVALID !== 1'b0) $display("FAIL wr_awvalid_drop got 1 want 0"); else n_pass++;
            end
            @(negedge ACLK);
        end
        n_checks++;
        if ({M_BREADY, M_WVALID} !== 2'b10) $display("FAIL wr_bready got bready/wvalid %b want 10", {M_BREADY, M_WVALID}); else n_pass++;
        M_BVALID = 1'b1;
        M_BRESP  = 2'b00;
        M_BID    = 4'd6;
        @(negedge ACLK);
        M_BVALID = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_errs, rsp_proto_err, M_BREADY} !== {1'b1, 2'b00, 5'd0, 1'b0, 1'b0})
            $display("FAIL wr_rsp got valid %0b resp %0d errs %0d proto %0b bready %0b want 1 0 0 0 0",
                     rsp_valid, rsp_resp, rsp_errs, rsp_proto_err, M_BREADY);
        else n_pass++;
        accept_rsp();
        n_checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL wr_back_idle got %b want 01", {rsp_valid, cmd_ready}); else n_pass++;
    endtask

    task automatic test_aw_delay();
        M_AWREADY = 1'b0;
        M_WREADY  = 1'b1;
        // Misaligned start and a seed that wraps on the second beat.
        issue_cmd(1'b1, 32'h207, 4'd1, 4'd9, 32'hFFFF_FFFF);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({M_AWVALID, M_AWADDR, M_AWLEN, M_BREADY} !== {1'b1, 32'h204, 8'd1, 1'b0})
                $display("FAIL awd_hold cycle %0d got awvalid %0b addr %0h len %0d bready %0b", c, M_AWVALID, M_AWADDR, M_AWLEN, M_BREADY);
            else n_pass++;
            n_checks++;
            if (M_WVALID !== (c < 2)) $display("FAIL awd_wvalid cycle %0d got %0b want %0b", c, M_WVALID, (c < 2)); else n_pass++;
            if (c < 2) begin
                n_checks++;
                if ({M_WDATA, M_WLAST} !== {(c == 0) ? 32'hFFFF_FFFF : 32'h0, (c == 1)})
                    $display("FAIL awd_wbeat %0d got data %0h last %0b", c, M_WDATA, M_WLAST);
                else n_pass++;
            end
            @(negedge ACLK);
        end
        M_AWREADY = 1'b1;
        @(negedge ACLK);
        M_AWREADY = 1'b0;
        n_checks++;
        if ({M_AWVALID, M_BREADY} !== 2'b01) $display("FAIL awd_after_aw got awvalid/bready %b want 01", {M_AWVALID, M_BREADY}); else n_pass++;
        M_BVALID = 1'b1;
        M_BRESP  = 2'b01;
        M_BID    = 4'd9;
        @(negedge ACLK);
        M_BVALID = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_proto_err} !== {1'b1, 2'b01, 1'b0})
            $display("FAIL awd_rsp got valid %0b resp %0d proto %0b want 1 1 0", rsp_valid, rsp_resp, rsp_proto_err);
        else n_pass++;
        accept_rsp();
    endtask

    task automatic test_read_mismatch();
        issue_cmd(1'b0, 32'h2000, 4'd15, 4'd5, 32'h10);
        n_checks++;
        if ({M_ARVALID, M_ARADDR, M_ARLEN, M_ARID, M_AWVALID} !== {1'b1, 32'h2000, 8'd15, 4'd5, 1'b0})
            $display("FAIL rd_ar got valid %0b addr %0h len %0d id %0d awvalid %0b", M_ARVALID, M_ARADDR, M_ARLEN, M_ARID, M_AWVALID);
        else n_pass++;
        M_ARREADY = 1'b1;
        @(negedge ACLK);
        M_ARREADY = 1'b0;
        n_checks++;
        if ({M_ARVALID, M_RREADY} !== 2'b01) $display("FAIL rd_rready got arvalid/rready %b want 01", {M_ARVALID, M_RREADY}); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            M_RVALID = 1'b1;
            M_RDATA  = (k == 7) ? 32'h0 : 32'h10 + 32'(k);
            M_RID    = 4'd5;
            M_RRESP  = 2'b00;
            M_RLAST  = (k == 15);
            @(negedge ACLK);
        end
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_errs, rsp_resp, rsp_proto_err, M_RREADY} !== {1'b1, 5'd1, 2'b00, 1'b0, 1'b0})
            $display("FAIL rd_mis_rsp got valid %0b errs %0d resp %0d proto %0b rready %0b want 1 1 0 0 0",
                     rsp_valid, rsp_errs, rsp_resp, rsp_proto_err, M_RREADY);
        else n_pass++;
        accept_rsp();
    endtask

    task automatic test_read_proto();
        issue_cmd(1'b0, 32'h3000, 4'd3, 4'd2, 32'h40);
        M_ARREADY = 1'b1;
        @(negedge ACLK);
        M_ARREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            M_RVALID = 1'b1;
            M_RDATA  = 32'h40 + 32'(k);
            M_RID    = (k == 0) ? 4'd3 : 4'd2;
            M_RRESP  = (k == 1) ? 2'b10 : ((k == 2) ? 2'b01 : 2'b00);
            M_RLAST  = (k == 2);
            @(negedge ACLK);
        end
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({rsp_valid, rsp_resp, rsp_errs, rsp_proto_err} !== {1'b1, 2'b10, 5'd0, 1'b1})
                $display("FAIL rd_proto_rsp cycle %0d got valid %0b resp %0d errs %0d proto %0b want 1 2 0 1",
                         c, rsp_valid, rsp_resp, rsp_errs, rsp_proto_err);
            else n_pass++;
            if (c < 2) @(negedge ACLK);
        end
        accept_rsp();
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL rd_proto_drop got 1 want 0"); else n_pass++;
    endtask

    task automatic test_4k_boundary();
        issue_cmd(1'b1, 32'hFF8, 4'd3, 4'd1, 32'h0);
        n_checks++;
        if ({M_AWVALID, M_WVALID, rsp_valid, rsp_resp, rsp_proto_err, cmd_ready} !== {1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0})
            $display("FAIL b4k_reject got awv %0b wv %0b rspv %0b resp %0d proto %0b rdy %0b want 0 0 1 2 1 0",
                     M_AWVALID, M_WVALID, rsp_valid, rsp_resp, rsp_proto_err, cmd_ready);
        else n_pass++;
        accept_rsp();
        // Ends exactly on the page boundary: accepted, status cleared.
        issue_cmd(1'b0, 32'hFF0, 4'd3, 4'd1, 32'h0);
        n_checks++;
        if ({M_ARVALID, M_ARADDR, rsp_valid, rsp_resp, rsp_proto_err} !== {1'b1, 32'hFF0, 1'b0, 2'b00, 1'b0})
            $display("FAIL b4k_edge_ok got arv %0b addr %0h rspv %0b resp %0d proto %0b",
                     M_ARVALID, M_ARADDR, rsp_valid, rsp_resp, rsp_proto_err);
        else n_pass++;
        M_ARREADY = 1'b1;
        @(negedge ACLK);
        M_ARREADY = 1'b0;
        for (int k = 0; k < 4; k++) begin
            M_RVALID = 1'b1;
            M_RDATA  = 32'(k);
            M_RID    = 4'd1;
            M_RRESP  = 2'b00;
            M_RLAST  = (k == 3);
            @(negedge ACLK);
        end
        M_RVALID = 1'b0;
        M_RLAST  = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_errs, rsp_proto_err} !== {1'b1, 5'd0, 1'b0})
            $display("FAIL b4k_edge_rsp got valid %0b errs %0d proto %0b want 1 0 0", rsp_valid, rsp_errs, rsp_proto_err);
        else n_pass++;
        accept_rsp();
    endtask

    task automatic test_reset_mid_burst();
        M_AWREADY = 1'b1;
        M_WREADY  = 1'b1;
        issue_cmd(1'b1, 32'h400, 4'd3, 4'd4, 32'h30);
        @(negedge ACLK);
        @(negedge ACLK);
        n_checks++;
        if (M_WDATA !== 32'h32) $display("FAIL rmb_beat2 got %0h want 32", M_WDATA); else n_pass++;
        ARESET = 1'b1;
        #1;
        n_checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid} !== 6'b0)
            $display("FAIL rmb_async_drop got %b want 000000",
                     {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid});
        else n_pass++;
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if ({rsp_valid, cmd_ready, M_WVALID} !== 3'b010) $display("FAIL rmb_after got rspv/rdy/wv %b want 010", {rsp_valid, cmd_ready, M_WVALID}); else n_pass++;
        issue_cmd(1'b1, 32'h500, 4'd0, 4'd7, 32'h55);
        n_checks++;
        if ({M_AWVALID, M_WVALID, M_WDATA, M_WLAST} !== {1'b1, 1'b1, 32'h55, 1'b1})
            $display("FAIL rmb_new_w got awv %0b wv %0b data %0h last %0b", M_AWVALID, M_WVALID, M_WDATA, M_WLAST);
        else n_pass++;
        @(negedge ACLK);
        n_checks++;
        if (M_BREADY !== 1'b1) $display("FAIL rmb_new_bready got 0 want 1"); else n_pass++;
        M_BVALID = 1'b1;
        M_BRESP  = 2'b00;
        M_BID    = 4'd7;
        @(negedge ACLK);
        M_BVALID = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_resp, rsp_proto_err} !== {1'b1, 2'b00, 1'b0})
            $display("FAIL rmb_new_rsp got valid %0b resp %0d proto %0b want 1 0 0", rsp_valid, rsp_resp, rsp_proto_err);
        else n_pass++;
        accept_rsp();
    endtask

    initial begin
        ARESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        cmd_id    = '0;
        cmd_seed  = '0;
        rsp_ready = 1'b0;
        M_AWREADY = 1'b0;
        M_WREADY  = 1'b0;
        M_BID     = '0;
        M_BRESP   = '0;
        M_BVALID  = 1'b0;
        M_ARREADY = 1'b0;
        M_RID     = '0;
        M_RDATA   = '0;
        M_RRESP   = '0;
        M_RLAST   = 1'b0;
        M_RVALID  = 1'b0;

        test_reset();
        test_write();
        test_aw_delay();
        test_read_mismatch();
        test_read_proto();
        test_4k_boundary();
        test_reset_mid_burst();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
